i2c_codec_responder: RTL and testbench

- I2C target (responder) implementing the codec side of the WM8731 control write protocol; the counterpart of the team's I2C initializer.
- Oversamples SCL/SDA on the system clock, ACKs valid 3-byte write frames, and emits one decoded register write per frame.
- Used as the synthesizable codec-control model in the audio top-level bench, and as a write monitor/logger on hardware.

---
 rtl/i2c_codec_responder.sv | 118 +++++++++++
 tb/tb_i2c_codec_responder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/i2c_codec_responder.sv
// i2c_codec_responder: I2C target that ACKs WM8731-style 3-byte control writes and reports each decoded register write.
module i2c_codec_responder #(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oen,
  output logic       o_wr_valid,
  output logic [6:0] o_reg_addr,
  output logic [8:0] o_reg_data,
  output logic       o_busy,
  output logic       o_err,
  output logic [7:0] o_wr_count
);
  typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, BYTE1, ACK1, BYTE2, ACK2, EXTRA, IGNORE} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_prev, sda_prev, scl_s, sda_s;
  logic scl_rise, scl_fall, start_c, stop_c, in_data, in_ack;
  logic [2:0] bit_cnt;
  logic bit_seen;
  logic [7:0] sr, byte1, byte2;
  always_comb begin
    scl_s    = scl_sync[SYNC_STAGES-1];
    sda_s    = sda_sync[SYNC_STAGES-1];
    scl_rise = scl_s & ~scl_prev;
    scl_fall = ~scl_s & scl_prev;
    start_c  = scl_s & scl_prev & sda_prev & ~sda_s;
    stop_c   = scl_s & scl_prev & ~sda_prev & sda_s;
    in_data  = state inside {ADDR, BYTE1, BYTE2, EXTRA};
    in_ack   = state inside {ADDR_ACK, ACK1, ACK2};
  end
  // A bit only counts once its SCL high phase ends, so the SCL rise that precedes STOP is not an extra bit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      scl_sync   <= '1;
      sda_sync   <= '1;
      scl_prev   <= 1'b1;
      sda_prev   <= 1'b1;
      state      <= IDLE;
      bit_cnt    <= '0;
      bit_seen   <= 1'b0;
      sr         <= '0;
      byte1      <= '0;
      byte2      <= '0;
      o_sda_oen  <= 1'b0;
      o_wr_valid <= 1'b0;
      o_reg_addr <= '0;
      o_reg_data <= '0;
      o_busy     <= 1'b0;
      o_err      <= 1'b0;
      o_wr_count <= '0;
    end else begin
      scl_sync   <= {scl_sync[SYNC_STAGES-2:0], i_scl};
      sda_sync   <= {sda_sync[SYNC_STAGES-2:0], i_sda};
      scl_prev   <= scl_s;
      sda_prev   <= sda_s;
      o_wr_valid <= 1'b0;
      o_err      <= 1'b0;
      if (start_c) begin
        state     <= ADDR;
        bit_cnt   <= '0;
        bit_seen  <= 1'b0;
        o_sda_oen <= 1'b0;
        o_busy    <= 1'b1;
      end else if (stop_c) begin
        state     <= IDLE;
        bit_cnt   <= '0;
        bit_seen  <= 1'b0;
        o_sda_oen <= 1'b0;
        o_busy    <= 1'b0;
        if (state == EXTRA && bit_cnt == 3'd0) begin
          o_wr_valid <= 1'b1;
          o_reg_addr <= byte1[7:1];
          o_reg_data <= {byte1[0], byte2};
          o_wr_count <= o_wr_count + 8'd1;
        end else if (state != IDLE && state != IGNORE) begin
          o_err <= 1'b1;
        end
      end else if (scl_rise && in_data) begin
        sr       <= {sr[6:0], sda_s};
        bit_seen <= 1'b1;
      end else if (scl_fall && in_ack) begin
        bit_cnt   <= '0;
        o_sda_oen <= 1'b0;
        state     <= state == ADDR_ACK ? BYTE1 : state == ACK1 ? BYTE2 : EXTRA;
      end else if (scl_fall && in_data && bit_seen) begin
        bit_seen <= 1'b0;
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          case (state)
            ADDR: begin
              state     <= (sr[7:1] == DEV_ADDR && !sr[0]) ? ADDR_ACK : IGNORE;
              o_sda_oen <= sr[7:1] == DEV_ADDR && !sr[0];
            end
            BYTE1: begin
              byte1     <= sr;
              state     <= ACK1;
              o_sda_oen <= 1'b1;
            end
            BYTE2: begin
              byte2     <= sr;
              state     <= ACK2;
              o_sda_oen <= 1'b1;
            end
            default: begin
              o_err <= 1'b1;
              state <= IGNORE;
            end
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_i2c_codec_responder.sv
// tb_i2c_codec_responder: table-driven I2C write frames plus hand-written repeated-START and mid-frame reset sequences.
module tb_i2c_codec_responder;
  localparam int Q = 8;
  typedef struct {
    logic [31:0] bytes;
    int          n;
    logic [3:0]  ack;
    int          nvalid;
    int          nerr;
    logic [6:0]  addr;
    logic [8:0]  data;
    logic [7:0]  cnt;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, scl = 1'b1, m_sda = 1'b1;
  logic sda_bus, sda_oen, wr_valid, busy, err;
  logic [6:0] reg_addr;
  logic [8:0] reg_data;
  logic [7:0] wr_count;
  int checks = 0, errors = 0, valid_cnt = 0, err_cnt = 0;
  vec_t tv [7];
  assign sda_bus = m_sda & ~sda_oen;
  always #5 clk = ~clk;
  i2c_codec_responder dut (
    .i_clk(clk), .i_rst(rst), .i_scl(scl), .i_sda(sda_bus),
    .o_sda_oen(sda_oen), .o_wr_valid(wr_valid), .o_reg_addr(reg_addr),
    .o_reg_data(reg_data), .o_busy(busy), .o_err(err), .o_wr_count(wr_count)
  );
  always @(negedge clk) begin
    if (wr_valid) valid_cnt++;
    if (err) err_cnt++;
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic i2c_start;
    m_sda = 1'b1; tick(Q);
    scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    scl = 1'b0; tick(Q);
  endtask
  task automatic i2c_stop;
    m_sda = 1'b0; tick(Q);
    scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(2 * Q);
  endtask
  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; tick(Q);
      scl = 1'b1; tick(2 * Q);
      scl = 1'b0; tick(Q);
    end
  endtask
  task automatic ack_slot(output logic a);
    m_sda = 1'b1; tick(Q);
    scl = 1'b1; tick(Q);
    a = ~sda_bus; tick(Q);
    scl = 1'b0; tick(Q);
  endtask
  initial begin
    int v0, e0;
    logic a;
    logic [3:0] acks;
    tv[0] = '{32'h34081500, 3, 4'b0111, 1, 0, 7'h04, 9'h015, 8'd1};
    tv[1] = '{32'h34058000, 3, 4'b0111, 1, 0, 7'h02, 9'h180, 8'd2};
    tv[2] = '{32'h341E0000, 3, 4'b0111, 1, 0, 7'h0F, 9'h000, 8'd3};
    tv[3] = '{32'h361E0000, 3, 4'b0000, 0, 0, 7'h0F, 9'h000, 8'd3};
    tv[4] = '{32'h35000000, 3, 4'b0000, 0, 0, 7'h0F, 9'h000, 8'd3};
    tv[5] = '{32'h341E0000, 2, 4'b0011, 0, 1, 7'h0F, 9'h000, 8'd3};
    tv[6] = '{32'h341E00AA, 4, 4'b0111, 0, 1, 7'h0F, 9'h000, 8'd3};
    tick(3);
    chk("rst_oen", sda_oen, 0);
    chk("rst_valid", wr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_count", wr_count, 0);
    chk("rst_addr", reg_addr, 0);
    chk("rst_data", reg_data, 0);
    rst = 1'b0;
    tick(4);
    for (int f = 0; f < 7; f++) begin
      v0 = valid_cnt;
      e0 = err_cnt;
      acks = '0;
      i2c_start;
      chk($sformatf("v%0d_busy_start", f), busy, 1);
      for (int k = 0; k < tv[f].n; k++) begin
        send_bits(tv[f].bytes[31 - 8 * k -: 8]);
        ack_slot(a);
        acks[k] = a;
      end
      i2c_stop;
      tick(2);
      chk($sformatf("v%0d_acks", f), acks, tv[f].ack);
      chk($sformatf("v%0d_valid", f), valid_cnt - v0, tv[f].nvalid);
      chk($sformatf("v%0d_err", f), err_cnt - e0, tv[f].nerr);
      chk($sformatf("v%0d_addr", f), reg_addr, tv[f].addr);
      chk($sformatf("v%0d_data", f), reg_data, tv[f].data);
      chk($sformatf("v%0d_count", f), wr_count, tv[f].cnt);
      chk($sformatf("v%0d_busy_stop", f), busy, 0);
    end
    v0 = valid_cnt;
    e0 = err_cnt;
    i2c_start;
    send_bits(8'h34); ack_slot(a);
    send_bits(8'h1E); ack_slot(a);
    i2c_start;
    chk("rs_busy", busy, 1);
    chk("rs_valid_mid", valid_cnt - v0, 0);
    send_bits(8'h34); ack_slot(a);
    send_bits(8'h0C); ack_slot(a);
    send_bits(8'h00); ack_slot(a);
    chk("rs_ack_last", a, 1);
    i2c_stop;
    tick(2);
    chk("rs_valid", valid_cnt - v0, 1);
    chk("rs_err", err_cnt - e0, 0);
    chk("rs_addr", reg_addr, 7'h06);
    chk("rs_data", reg_data, 9'h000);
    chk("rs_count", wr_count, 8'd4);
    i2c_start;
    send_bits(8'h34); ack_slot(a);
    send_bits(8'h1E);
    chk("ar_oen_before", sda_oen, 1);
    rst = 1'b1;
    #1;
    chk("ar_oen_async", sda_oen, 0);
    chk("ar_busy", busy, 0);
    chk("ar_count", wr_count, 0);
    tick(2);
    rst = 1'b0;
    tick(4);
    e0 = err_cnt;
    i2c_stop;
    tick(2);
    chk("ar_stop_silent", err_cnt - e0, 0);
    v0 = valid_cnt;
    acks = '0;
    i2c_start;
    send_bits(8'h34); ack_slot(a); acks[0] = a;
    send_bits(8'h1E); ack_slot(a); acks[1] = a;
    send_bits(8'h00); ack_slot(a); acks[2] = a;
    i2c_stop;
    tick(2);
    chk("ar_acks", acks, 4'b0111);
    chk("ar_valid", valid_cnt - v0, 1);
    chk("ar_addr", reg_addr, 7'h0F);
    chk("ar_data", reg_data, 9'h000);
    chk("ar_count_after", wr_count, 8'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
